// File: rtl/led_pwm_gen.sv
// Multi-channel PWM back end: double-buffered duties, applied only at a period boundary.
// Optional gamma correction is enabled by defining LED_PWM_GAMMA_EN.
module led_pwm_gen #(
  parameter int CH       = 8,
  parameter int DW       = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH*DW-1:0] duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic [CH-1:0]    pwm_out,
  output logic             period_start
);

  localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);
  // Last counter value is 2**DW-2, so a full-scale duty never sees a low cycle.
  localparam logic [DW-1:0]  CNT_LAST = {{(DW-1){1'b1}}, 1'b0};

  logic [PW-1:0]          r_pre_cnt;
  logic [DW-1:0]          r_cnt;
  logic [CH-1:0][DW-1:0]  r_active;
  logic [CH-1:0][DW-1:0]  r_pending;
  logic                   r_pend_full;
  logic                   r_in_reset;
  logic                   r_period_start;
  logic [CH-1:0]          r_pwm;

  logic [CH-1:0][DW-1:0]  w_eff;
  logic                   w_tick;
  logic                   w_wrap;
  logic                   w_xfer;

  assign w_tick       = (r_pre_cnt == PRE_LAST);
  assign w_wrap       = w_tick && (r_cnt == CNT_LAST);
  assign duty_ready   = !r_pend_full && !r_in_reset;
  assign w_xfer       = duty_valid && duty_ready;
  assign pwm_out      = r_pwm;
  assign period_start = r_period_start;

`ifdef LED_PWM_GAMMA_EN
  logic [CH-1:0][2*DW-1:0] w_prod;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_prod = '0;
    w_eff  = '0;
    for (int i = 0; i < CH; i++) begin
      w_prod[i] = {{DW{1'b0}}, r_active[i]} * ({{DW{1'b0}}, r_active[i]} + 1'b1);
      w_eff[i]  = w_prod[i][2*DW-1:DW];
    end
  end
`else
  assign w_eff = r_active;
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre_cnt      <= '0;
      r_cnt          <= '0;
      r_active       <= '0;
      r_pending      <= '0;
      r_pend_full    <= 1'b0;
      r_in_reset     <= 1'b1;
      r_period_start <= 1'b0;
      r_pwm          <= '0;
    end else begin
      r_in_reset     <= 1'b0;
      r_period_start <= w_wrap;

      if (w_tick) r_pre_cnt <= '0;
      else        r_pre_cnt <= r_pre_cnt + 1'b1;

      if (w_wrap)      r_cnt <= '0;
      else if (w_tick) r_cnt <= r_cnt + 1'b1;

      // Transfer needs an empty pending buffer, so it can never collide with an apply.
      if (w_wrap && r_pend_full) begin
        r_active    <= r_pending;
        r_pend_full <= 1'b0;
      end else if (w_xfer) begin
        r_pending   <= duty_in;
        r_pend_full <= 1'b1;
      end

      for (int i = 0; i < CH; i++) r_pwm[i] <= (r_cnt < w_eff[i]);
    end
  end

endmodule

// File: tb/tb_led_pwm_gen.sv
// Directed bench for led_pwm_gen: reset, duty sweep table, handshake, prescaler, reset mid-period.
module tb_led_pwm_gen;
  localparam int CH = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst, duty_valid, duty_ready, period_start;
  logic [CH-1:0][DW-1:0] duty_in;
  logic [CH-1:0]         pwm_out;

  logic                  p4_rst, p4_valid, p4_ready, p4_ps;
  logic [CH-1:0][DW-1:0] p4_duty;
  logic [CH-1:0]         p4_pwm;

  led_pwm_gen #(.CH(CH), .DW(DW), .PRESCALE(1)) dut (
    .clk(clk), .rst(rst), .duty_in(duty_in), .duty_valid(duty_valid),
    .duty_ready(duty_ready), .pwm_out(pwm_out), .period_start(period_start));

  led_pwm_gen #(.CH(CH), .DW(DW), .PRESCALE(4)) dut4 (
    .clk(clk), .rst(p4_rst), .duty_in(p4_duty), .duty_valid(p4_valid),
    .duty_ready(p4_ready), .pwm_out(p4_pwm), .period_start(p4_ps));

  typedef struct packed {
    logic [CH-1:0][DW-1:0] duty;
    logic [CH-1:0][9:0]    hi;   // expected high cycles per 255-cycle period
  } vec_t;

  vec_t tbl [3];
  int   checks = 0;
  int   errors = 0;
  int   hi [CH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_hi();
    for (int c = 0; c < CH; c++) hi[c] = 0;
  endtask

  task automatic sample_acc();
    step();
    for (int c = 0; c < CH; c++) hi[c] += int'(pwm_out[c]);
  endtask

  task automatic measure(input int n);
    for (int k = 0; k < n; k++) sample_acc();
  endtask

  task automatic load(input logic [CH-1:0][DW-1:0] v, input string name);
    int n = 0;
    while (!duty_ready && n < 2000) begin step(); n++; end
    check({name, "_ready_wait"}, 64'(duty_ready), 64'd1);
    duty_in    = v;
    duty_valid = 1'b1;
    step();
    duty_valid = 1'b0;
    check({name, "_accepted"}, 64'(duty_ready), 64'd0);
  endtask

  task automatic wait_apply(input string name);
    int n = 0;
    while (!duty_ready && n < 600) begin step(); n++; end
    check({name, "_apply_ready"}, 64'(duty_ready), 64'd1);
    check({name, "_apply_wrap"}, 64'(period_start), 64'd1);
  endtask

  initial begin
    logic [CH-1:0][DW-1:0] va, vb, vc, vd, ve;
    int n, cnt_hi, wraps, bad;

    rst = 1'b1; p4_rst = 1'b1; duty_valid = 1'b0; p4_valid = 1'b0;
    duty_in = '0; p4_duty = '0;

    // 1: reset held 3 cycles, then idle with no load
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("rst_pwm_%0d", k), 64'(pwm_out), 64'd0);
      check($sformatf("rst_ready_%0d", k), 64'(duty_ready), 64'd0);
      check($sformatf("rst_ps_%0d", k), 64'(period_start), 64'd0);
    end
    rst = 1'b0; p4_rst = 1'b0;
    step();
    check("ready_after_rst", 64'(duty_ready), 64'd1);
    check("ready4_after_rst", 64'(p4_ready), 64'd1);
    cnt_hi = 0;
    for (int k = 0; k < 600; k++) begin step(); cnt_hi += int'($countones(pwm_out)); end
    check("idle_pwm_off", 64'(cnt_hi), 64'd0);

    // 4: prescaler 4, duty 64
    for (int c = 0; c < CH; c++) p4_duty[c] = 8'd64;
    p4_valid = 1'b1;
    step();
    p4_valid = 1'b0;
    check("p4_accepted", 64'(p4_ready), 64'd0);
    n = 0;
    while (!p4_ready && n < 3000) begin step(); n++; end
    check("p4_apply_wrap", 64'(p4_ps), 64'd1);
    for (int r = 0; r < 2; r++) begin
      n = 0; cnt_hi = 0;
      do begin step(); n++; cnt_hi += int'(p4_pwm[0]); end while (!p4_ps && n < 3000);
      check($sformatf("p4_period_%0d", r), 64'(n), 64'd1020);
`ifdef LED_PWM_GAMMA_EN
      check($sformatf("p4_high_%0d", r), 64'(cnt_hi), 64'd64);
`else
      check($sformatf("p4_high_%0d", r), 64'(cnt_hi), 64'd256);
`endif
    end

    // 2: duty sweep table, two full periods per row (covers the wrap)
    tbl[0].duty = {8'd255, 8'd128, 8'd1, 8'd0, 8'd255, 8'd128, 8'd1, 8'd0};
    tbl[1].duty = {8'd200, 8'd64, 8'd254, 8'd2, 8'd16, 8'd255, 8'd15, 8'd128};
    tbl[2].duty = {CH{8'd255}};
`ifdef LED_PWM_GAMMA_EN
    tbl[0].hi = {10'd255, 10'd64, 10'd0, 10'd0, 10'd255, 10'd64, 10'd0, 10'd0};
    tbl[1].hi = {10'd157, 10'd16, 10'd253, 10'd0, 10'd1, 10'd255, 10'd0, 10'd64};
`else
    tbl[0].hi = {10'd255, 10'd128, 10'd1, 10'd0, 10'd255, 10'd128, 10'd1, 10'd0};
    tbl[1].hi = {10'd200, 10'd64, 10'd254, 10'd2, 10'd16, 10'd255, 10'd15, 10'd128};
`endif
    tbl[2].hi = {CH{10'd255}};
    for (int v = 0; v < 3; v++) begin
      load(tbl[v].duty, $sformatf("vec%0d", v));
      wait_apply($sformatf("vec%0d", v));
      clear_hi();
      measure(510);
      for (int c = 0; c < CH; c++)
        check($sformatf("vec%0d_ch%0d_high", v, c), 64'(hi[c]), 64'(2 * int'(tbl[v].hi[c])));
    end

    // 3: handshake; A drives first period while B waits
    for (int c = 0; c < CH; c++) begin
      va[c] = (c % 2 == 0) ? 8'd255 : 8'd0;
      vb[c] = (c % 2 == 0) ? 8'd0 : 8'd255;
      vc[c] = (c < 2) ? 8'd255 : 8'd0;
      vd[c] = 8'd200;
      ve[c] = 8'h55;
    end
    load(va, "hs_a");
    duty_in = vb; duty_valid = 1'b1;
    n = 0; bad = 0;
    while (!period_start && n < 600) begin
      bad += int'(duty_ready);
      step(); n++;
    end
    check("hs_ready_low_pending", 64'(bad), 64'd0);
    check("hs_wrap_ready", 64'(duty_ready), 64'd1);
    clear_hi();
    sample_acc();
    duty_valid = 1'b0;
    check("hs_b_accepted", 64'(duty_ready), 64'd0);
    measure(254);
    check("hs_first_a_ch0", 64'(hi[0]), 64'd255);
    check("hs_first_a_ch1", 64'(hi[1]), 64'd0);
    check("hs_b_wrap", 64'(period_start), 64'd1);
    clear_hi();
    measure(255);
    check("hs_b_ch0", 64'(hi[0]), 64'd0);
    check("hs_b_ch1", 64'(hi[1]), 64'd255);

    // 3b: transfer on the wrap cycle is applied one period later
    for (int k = 0; k < 254; k++) step();
    check("wx_ready", 64'(duty_ready), 64'd1);
    duty_in = vc; duty_valid = 1'b1;
    step();
    duty_valid = 1'b0;
    check("wx_wrap", 64'(period_start), 64'd1);
    check("wx_accepted", 64'(duty_ready), 64'd0);
    clear_hi();
    measure(255);
    check("wx_still_b_ch0", 64'(hi[0]), 64'd0);
    check("wx_still_b_ch1", 64'(hi[1]), 64'd255);
    check("wx_apply_wrap", 64'(period_start), 64'd1);
    check("wx_apply_ready", 64'(duty_ready), 64'd1);
    clear_hi();
    measure(255);
    check("wx_c_ch0", 64'(hi[0]), 64'd255);
    check("wx_c_ch1", 64'(hi[1]), 64'd255);
    check("wx_c_ch2", 64'(hi[2]), 64'd0);

    // 5: reset at cnt=100 with duty 200 active and a set pending
    load(vd, "mr_d");
    wait_apply("mr_d");
    duty_in = ve; duty_valid = 1'b1;
    step();
    duty_valid = 1'b0;
    check("mr_pending", 64'(duty_ready), 64'd0);
    for (int k = 0; k < 99; k++) step();
    check("mr_pwm_before", 64'(pwm_out), 64'hFF);
    rst = 1'b1;
    step();
    check("mr_pwm_off", 64'(pwm_out), 64'd0);
    check("mr_ready_low", 64'(duty_ready), 64'd0);
    check("mr_ps_low", 64'(period_start), 64'd0);
    rst = 1'b0;
    step();
    check("mr_ready_after", 64'(duty_ready), 64'd1);
    cnt_hi = 0; wraps = 0;
    for (int k = 0; k < 600; k++) begin
      step();
      cnt_hi += int'($countones(pwm_out));
      wraps  += int'(period_start);
    end
    check("mr_stays_off", 64'(cnt_hi), 64'd0);
    check("mr_wraps", 64'(wraps), 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
